// File: rtl/ultrasonic_ranging_sequencer.sv
// Ultrasonic ranging sequencer: periodic trigger pulse, echo measurement window and
// synchronised echo forwarding for the downstream distance counter.
module ultrasonic_ranging_sequencer #(
  parameter int TRIG_CYCLES   = 1000,
  parameter int WINDOW_CYCLES = 3000000,
  parameter int PERIOD_CYCLES = 6000000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic echo_in,
  output logic trig_out,
  output logic disStart,
  output logic detect,
  output logic busy,
  output logic timeout
);

  localparam logic [31:0] TRIG_LAST   = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] WIN_LAST    = 32'(WINDOW_CYCLES - 1);
  localparam logic [31:0] PERIOD_LAST = 32'(PERIOD_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLD} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync;
  logic                   echo_s, echo_s_d, echo_rise;
  logic [31:0]            period_cnt, window_cnt;
  logic                   to_flag, to_pend;
  logic                   trig_d, dis_d, det_d, busy_d;

  assign echo_s    = sync[SYNC_STAGES-1];
  assign echo_rise = echo_s & ~echo_s_d;

  // Echo synchroniser plus one delay flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync     <= '0;
      echo_s_d <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], echo_in};
      echo_s_d <= echo_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A rise seen on the first window cycle means echo was already high on entry: stale.
  always_comb begin
    state_next = state;
    to_flag    = 1'b0;
    case (state)
      IDLE:      if (enable) state_next = TRIG;
      TRIG:      if (period_cnt == TRIG_LAST) state_next = WAIT_ECHO;
      WAIT_ECHO: begin
        if (echo_rise && window_cnt != '0) begin
          state_next = MEASURE;
        end else if (window_cnt == WIN_LAST) begin
          state_next = HOLD;
          to_flag    = 1'b1;
        end
      end
      MEASURE: begin
        if (!echo_s) begin
          state_next = HOLD;
        end else if (window_cnt == WIN_LAST) begin
          state_next = HOLD;
          to_flag    = 1'b1;
        end
      end
      HOLD:      if (period_cnt == PERIOD_LAST) state_next = enable ? TRIG : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
      window_cnt <= '0;
    end else begin
      if (state_next == TRIG && state != TRIG) period_cnt <= '0;
      else if (period_cnt != PERIOD_LAST)      period_cnt <= period_cnt + 32'd1;

      if (state == TRIG)                                 window_cnt <= '0;
      else if (state == WAIT_ECHO || state == MEASURE)   window_cnt <= window_cnt + 32'd1;
    end
  end

  // Outputs decode the current state; detect uses the delayed echo so it tracks
  // the one-cycle output lag and falls together with disStart.
  always_comb begin
    trig_d = (state == TRIG);
    dis_d  = (state == WAIT_ECHO) || (state == MEASURE);
    det_d  = (state == MEASURE) && echo_s_d;
    busy_d = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_out <= 1'b0;
      disStart <= 1'b0;
      detect   <= 1'b0;
      busy     <= 1'b0;
      to_pend  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      trig_out <= trig_d;
      disStart <= dis_d;
      detect   <= det_d;
      busy     <= busy_d;
      to_pend  <= to_flag;
      timeout  <= to_pend;
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranging_sequencer.sv
// Directed bench for ultrasonic_ranging_sequencer with short sim parameters.
module tb_ultrasonic_ranging_sequencer;

  logic clk = 1'b0;
  logic reset, enable, echo_in;
  logic trig_out, disStart, detect, busy, timeout;

  int n_checks = 0;
  int n_err    = 0;

  int cyc = 0;
  int n_rise = 0, last_rise = 0, prev_rise = 0;
  int trig_hi = 0, det_hi = 0, dis_hi = 0, to_hi = 0;
  int inv_err = 0, fall_err = 0;
  logic trig_q = 1'b0, det_q = 1'b0;

  ultrasonic_ranging_sequencer #(
    .TRIG_CYCLES(4), .WINDOW_CYCLES(50), .PERIOD_CYCLES(100), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .echo_in(echo_in),
    .trig_out(trig_out), .disStart(disStart), .detect(detect),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle activity counters, sampled on the inactive edge
  always @(negedge clk) begin
    if (trig_out && !trig_q) begin
      prev_rise = last_rise;
      last_rise = cyc;
      n_rise++;
    end
    trig_hi += int'(trig_out);
    det_hi  += int'(detect);
    dis_hi  += int'(disStart);
    to_hi   += int'(timeout);
    if (detect && !disStart) inv_err++;
    if (trig_out && disStart) inv_err++;
    if (det_q && !detect && disStart) fall_err++;
    trig_q = trig_out;
    det_q  = detect;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    trig_hi = 0; det_hi = 0; dis_hi = 0; to_hi = 0;
  endtask

  task automatic wait_rise(input int budget, output bit ok);
    int n0;
    n0 = n_rise;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (n_rise != n0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_trig_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!trig_out) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; echo_in = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({trig_out, disStart, detect, busy, timeout} !== 5'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b expected 00000", {trig_out, disStart, detect, busy, timeout});
    end
    clear_counts();
    reset = 1'b0;
    tick();
    n_checks++;
    if (trig_out !== 1'b0) begin n_err++; $display("FAIL trig_first_edge: got %b expected 0", trig_out); end
    tick();
    n_checks++;
    if (trig_out !== 1'b1) begin n_err++; $display("FAIL trig_second_edge: got %b expected 1", trig_out); end
  endtask

  task automatic test_echo_measure();
    bit ok;
    wait_trig_low(20, ok);
    n_checks++;
    if (!ok) begin n_err++; $display("FAIL echo_trig_fall: trig_out never fell"); end
    repeat (10) tick();
    echo_in = 1'b1;
    repeat (20) tick();
    echo_in = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (trig_hi !== 4) begin n_err++; $display("FAIL echo_trig_width: got %0d expected 4", trig_hi); end
    n_checks++;
    if (det_hi !== 20) begin n_err++; $display("FAIL echo_detect_width: got %0d expected 20", det_hi); end
    n_checks++;
    if (to_hi !== 0) begin n_err++; $display("FAIL echo_no_timeout: got %0d expected 0", to_hi); end
    n_checks++;
    if (fall_err !== 0 || disStart !== 1'b0) begin
      n_err++; $display("FAIL echo_joint_fall: fall_err %0d disStart %b expected 0 0", fall_err, disStart);
    end
  endtask

  task automatic test_no_echo();
    bit ok;
    wait_rise(200, ok);
    n_checks++;
    if (!ok || last_rise - prev_rise !== 100) begin
      n_err++; $display("FAIL noecho_period1: ok %0d gap %0d expected 100", ok, last_rise - prev_rise);
    end
    clear_counts();
    wait_rise(200, ok);
    n_checks++;
    if (!ok || last_rise - prev_rise !== 100) begin
      n_err++; $display("FAIL noecho_period2: ok %0d gap %0d expected 100", ok, last_rise - prev_rise);
    end
    n_checks++;
    if (dis_hi !== 50) begin n_err++; $display("FAIL noecho_window: got %0d expected 50", dis_hi); end
    n_checks++;
    if (to_hi !== 1) begin n_err++; $display("FAIL noecho_timeout: got %0d expected 1", to_hi); end
  endtask

  task automatic test_long_echo();
    bit ok;
    clear_counts();
    wait_trig_low(20, ok);
    repeat (10) tick();
    echo_in = 1'b1;
    repeat (80) tick();
    n_checks++;
    if (detect !== 1'b0) begin n_err++; $display("FAIL long_detect_low: got %b expected 0", detect); end
    echo_in = 1'b0;
    n_checks++;
    if (det_hi !== 36) begin n_err++; $display("FAIL long_detect_width: got %0d expected 36", det_hi); end
    n_checks++;
    if (dis_hi !== 50) begin n_err++; $display("FAIL long_window: got %0d expected 50", dis_hi); end
    n_checks++;
    if (to_hi !== 1) begin n_err++; $display("FAIL long_timeout: got %0d expected 1", to_hi); end
    wait_rise(200, ok);
    n_checks++;
    if (!ok || last_rise - prev_rise !== 100) begin
      n_err++; $display("FAIL long_period: ok %0d gap %0d expected 100", ok, last_rise - prev_rise);
    end
  endtask

  task automatic test_stale_echo();
    bit ok;
    clear_counts();
    echo_in = 1'b1;
    wait_trig_low(20, ok);
    repeat (5) tick();
    echo_in = 1'b0;
    repeat (10) tick();
    echo_in = 1'b1;
    repeat (8) tick();
    echo_in = 1'b0;
    repeat (30) tick();
    n_checks++;
    if (det_hi !== 8) begin n_err++; $display("FAIL stale_detect_width: got %0d expected 8", det_hi); end
    n_checks++;
    if (dis_hi !== 27) begin n_err++; $display("FAIL stale_window: got %0d expected 27", dis_hi); end
    n_checks++;
    if (to_hi !== 0) begin n_err++; $display("FAIL stale_timeout: got %0d expected 0", to_hi); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int n0;
    wait_rise(200, ok);
    n_checks++;
    if (!ok || last_rise - prev_rise !== 100) begin
      n_err++; $display("FAIL drop_period: ok %0d gap %0d expected 100", ok, last_rise - prev_rise);
    end
    clear_counts();
    wait_trig_low(20, ok);
    repeat (5) tick();
    echo_in = 1'b1;
    repeat (5) tick();
    enable = 1'b0;
    repeat (5) tick();
    echo_in = 1'b0;
    n0 = n_rise;
    repeat (250) tick();
    n_checks++;
    if (det_hi !== 10) begin n_err++; $display("FAIL drop_detect_width: got %0d expected 10", det_hi); end
    n_checks++;
    if (n_rise !== n0) begin n_err++; $display("FAIL drop_no_trigger: got %0d rises expected 0", n_rise - n0); end
    n_checks++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL drop_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    enable = 1'b1;
    wait_rise(20, ok);
    n_checks++;
    if (!ok) begin n_err++; $display("FAIL resume_trigger: no trig_out from IDLE"); end
    wait_trig_low(20, ok);
    repeat (5) tick();
    echo_in = 1'b1;
    repeat (8) tick();
    n_checks++;
    if ({disStart, detect} !== 2'b11) begin
      n_err++; $display("FAIL mid_measure: got %b expected 11", {disStart, detect});
    end
    reset = 1'b1;
    #2;
    n_checks++;
    if ({trig_out, disStart, detect, busy, timeout} !== 5'b0) begin
      n_err++; $display("FAIL async_reset: got %b expected 00000", {trig_out, disStart, detect, busy, timeout});
    end
    echo_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_checks++;
    if (trig_out !== 1'b0) begin n_err++; $display("FAIL rel_first_edge: got %b expected 0", trig_out); end
    tick();
    n_checks++;
    if (trig_out !== 1'b1) begin n_err++; $display("FAIL rel_second_edge: got %b expected 1", trig_out); end
  endtask

  initial begin
    test_reset();
    test_echo_measure();
    test_no_echo();
    test_long_echo();
    test_stale_echo();
    test_enable_drop();
    test_reset_mid();
    n_checks++;
    if (inv_err !== 0) begin n_err++; $display("FAIL output_invariants: got %0d violations expected 0", inv_err); end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
